// File: rtl/baud_tick_gen_if.sv
// Baud tick generator bus: divisor, channel enables, RX realign, tick/error outputs.
// master drives divisor/enables/rx_sync; slave (the generator) drives ticks and div_err.
interface baud_tick_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              tx_en;
  logic              rx_en;
  logic              rx_sync;
  logic              tick_tx;
  logic              tick_rx;
  logic              div_err;

  modport master (
    output div_int, div_frac, tx_en, rx_en, rx_sync,
    input  tick_tx, tick_rx, div_err
  );

  modport slave (
    input  div_int, div_frac, tx_en, rx_en, rx_sync,
    output tick_tx, tick_rx, div_err
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Dual-channel (TX/RX) baud tick generator with optional fractional divisor.
// Ports: pclk, preset (sync, active-high), bus (slave modport: div_int,
// div_frac, tx_en, rx_en, rx_sync in; tick_tx, tick_rx, div_err out).
// Macro BAUD_FRAC_EN enables the fractional accumulator; otherwise
// div_frac is ignored and every period is div_int cycles.

module baud_chan #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              tick_o
);
  localparam int PW = DIV_W + 1;

  // per_q is the shadow period; zero means "not started" so the
  // next enabled edge latches the divisor and begins counting.
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    per_q, per_d;
  logic             half_q, half_d;
  logic             tick_q, tick_d;
  logic [PW-1:0]    base;
  logic [DIV_W-1:0] half;
  logic             wrap;
  logic             carry;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;
`else
  logic unused_frac;
  assign unused_frac = ^frac_i;
`endif

  always_comb begin
    base = (div_i < DIV_W'(2)) ? PW'(2) : {1'b0, div_i};
    half = div_i >> 1;
    if (half == '0) half = DIV_W'(1);
    wrap = (per_q != '0) && ({1'b0, cnt_q} == per_q - PW'(1));
`ifdef BAUD_FRAC_EN
    sum   = {1'b0, acc_q} + {1'b0, frac_i};
    carry = sum[FRAC_W];
    acc_d = acc_q;
`else
    carry = 1'b0;
`endif
    cnt_d  = cnt_q;
    per_d  = per_q;
    half_d = half_q;
    tick_d = 1'b0;
    if (!en_i) begin
      cnt_d  = '0;
      per_d  = '0;
      half_d = 1'b0;
`ifdef BAUD_FRAC_EN
      acc_d  = '0;
`endif
    end else if (sync_i) begin
      // realign: run one half period, then full periods resume
      cnt_d  = '0;
      per_d  = {1'b0, half};
      half_d = 1'b1;
    end else if (per_q == '0) begin
      cnt_d  = '0;
      per_d  = base;
      half_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      half_d = 1'b0;
      if (half_q) begin
        // end of a realign half period leaves the accumulator alone
        per_d = base;
      end else begin
        per_d = base + PW'(carry);
`ifdef BAUD_FRAC_EN
        acc_d = sum[FRAC_W-1:0];
`endif
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      per_q  <= '0;
      half_q <= 1'b0;
      tick_q <= 1'b0;
`ifdef BAUD_FRAC_EN
      acc_q  <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      half_q <= half_d;
      tick_q <= tick_d;
`ifdef BAUD_FRAC_EN
      acc_q  <= acc_d;
`endif
    end
  end

  assign tick_o = tick_q;
endmodule

module baud_tick_gen #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic           pclk,
  input  logic           preset,
  baud_tick_gen_if.slave bus
);
  logic div_err_q, div_err_d;
  logic tx_tick, rx_tick;

  baud_chan #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_tx (
    .clk_i  (pclk),
    .rst_i  (preset),
    .en_i   (bus.tx_en),
    .sync_i (1'b0),
    .div_i  (bus.div_int),
    .frac_i (bus.div_frac),
    .tick_o (tx_tick)
  );

  baud_chan #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_rx (
    .clk_i  (pclk),
    .rst_i  (preset),
    .en_i   (bus.rx_en),
    .sync_i (bus.rx_sync),
    .div_i  (bus.div_int),
    .frac_i (bus.div_frac),
    .tick_o (rx_tick)
  );

  assign div_err_d = bus.div_int < DIV_W'(2);

  always_ff @(posedge pclk) begin
    if (preset) div_err_q <= 1'b0;
    else        div_err_q <= div_err_d;
  end

  assign bus.tick_tx = tx_tick;
  assign bus.tick_rx = rx_tick;
  assign bus.div_err = div_err_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: hand-computed tick cycles per scenario.
// Cycle n = n-th rising edge after reset release; outputs sampled on negedge.
module tb_baud_tick_gen;
  logic pclk = 1'b0;
  logic preset;
  int   t;
  int   ncmp = 0;
  int   nerr = 0;

  baud_tick_gen_if #(.DIV_W(16), .FRAC_W(4)) bus ();

  baud_tick_gen #(.DIV_W(16), .FRAC_W(4)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus.slave)
  );

  always #5 pclk = ~pclk;

  task automatic adv();
    @(posedge pclk);
    t++;
    @(negedge pclk);
  endtask

  task automatic chk(string tag, logic obs, logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s t=%0d obs=%0b exp=%0b", tag, t, obs, exp);
    end
  endtask

  function automatic logic hit(int v, int q[$]);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge pclk);
    preset = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    t = -1;
  endtask

  task automatic scan(int last, int qt[$], int qr[$]);
    while (t < last) begin
      adv();
      chk("tick_tx", bus.tick_tx, hit(t, qt));
      chk("tick_rx", bus.tick_rx, hit(t, qr));
    end
  endtask

  int none[$];
  int frac_q[$];

  initial begin
    none = {};
    preset       = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    bus.tx_en    = 1'b0;
    bus.rx_en    = 1'b0;
    bus.rx_sync  = 1'b0;

    // reset state, with div_int=0 present so div_err must be held low
    bus.tx_en = 1'b1;
    do_reset();
    chk("rst_tick_tx", bus.tick_tx, 1'b0);
    chk("rst_tick_rx", bus.tick_rx, 1'b0);
    chk("rst_div_err", bus.div_err, 1'b0);

    // div 4: ticks at 4, 8, 12
    bus.div_int = 16'd4;
    do_reset();
    scan(13, '{4, 8, 12}, none);

    // div 4 + 8/16: intervals 4,4,5,4,5 with fraction, else constant 4
    bus.div_frac = 4'd8;
`ifdef BAUD_FRAC_EN
    frac_q = '{4, 8, 13, 17, 22};
`else
    frac_q = '{4, 8, 12, 16, 20, 24};
`endif
    do_reset();
    scan(24, frac_q, none);
    bus.div_frac = '0;

    // RX realign: div 16, sync at 21 -> 29, 45, 61
    bus.tx_en   = 1'b0;
    bus.rx_en   = 1'b1;
    bus.div_int = 16'd16;
    do_reset();
    scan(20, none, '{16});
    bus.rx_sync = 1'b1;
    adv();
    bus.rx_sync = 1'b0;
    chk("tick_rx", bus.tick_rx, 1'b0);
    scan(62, none, '{29, 45, 61});

    // sync coinciding with wrap: tick at 8 suppressed, then 12, 20
    bus.div_int = 16'd8;
    do_reset();
    scan(7, none, none);
    bus.rx_sync = 1'b1;
    adv();
    bus.rx_sync = 1'b0;
    chk("sync_wrap_rx", bus.tick_rx, 1'b0);
    scan(21, none, '{12, 20});

    // sync while rx disabled is ignored
    bus.rx_en = 1'b0;
    do_reset();
    bus.rx_sync = 1'b1;
    adv();
    bus.rx_sync = 1'b0;
    scan(10, none, none);

    // div_int=1: clamp to 2 with div_err; then div 8 from next wrap
    bus.tx_en   = 1'b1;
    bus.div_int = 16'd1;
    do_reset();
    while (t < 26) begin
      if (t == 8) bus.div_int = 16'd8;
      adv();
      chk("tick_tx", bus.tick_tx, hit(t, '{2, 4, 6, 8, 10, 18, 26}));
      chk("div_err", bus.div_err, (t <= 8) ? 1'b1 : 1'b0);
    end

    // mid-run reset at cycle 7 drops the tick at 10; restart at 8 -> 18
    bus.div_int = 16'd10;
    do_reset();
    scan(6, none, none);
    preset = 1'b1;
    adv();
    preset = 1'b0;
    chk("midrst_tick_tx", bus.tick_tx, 1'b0);
    scan(19, '{18}, none);

    // tx drop at 6, re-raise at 9 -> 17, 25; rx keeps 8, 16, 24
    bus.div_int = 16'd8;
    bus.rx_en   = 1'b1;
    do_reset();
    scan(5, none, none);
    bus.tx_en = 1'b0;
    scan(8, none, '{8});
    bus.tx_en = 1'b1;
    scan(25, '{17, 25}, '{8, 16, 24});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, integer divisor width in bits.
REQ-002 SHALL have parameter FRAC_W, default 4, fractional divisor width in bits (used only under BAUD_FRAC_EN).
REQ-003 SHALL have port pclk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port preset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port div_int  input  DIV_W  integer pclk cycles per baud tick.
REQ-006 SHALL have port div_frac  input  FRAC_W  fractional divisor, units of 1/2^FRAC_W cycle.
REQ-007 SHALL have port tx_en  input  1  TX channel enable.
REQ-008 SHALL have port rx_en  input  1  RX channel enable.
REQ-009 SHALL have port rx_sync  input  1  single-cycle pulse; realign RX to a half period (start-bit edge).
REQ-010 SHALL have port tick_tx  output  1  registered one-cycle TX baud tick.
REQ-011 SHALL have port tick_rx  output  1  registered one-cycle RX baud tick.
REQ-012 SHALL have port div_err  output  1  registered flag, high while div_int < 2.
REQ-013 SHALL use one clock (pclk); reset preset is synchronous and active-high.

Function
REQ-014 SHALL implement two independent, identical channels (TX, RX), each with a DIV_W-bit counter cnt, a shadow divisor, and a FRAC_W-bit accumulator acc.
REQ-015 SHALL latch shadow divisor from div_int/div_frac on the first enabled cycle and on every wrap; mid-period div_int changes take effect at the next period.
REQ-016 SHALL clamp effective div_int to 2 when div_int < 2; div_err high the cycle after div_int < 2 is sampled.
REQ-017 While en low: cnt=0, acc=0, tick=0 on next edge.
REQ-018 While en high: cnt increments each cycle; when cnt == P-1 (P = current period), cnt returns to 0 and tick is set for exactly one cycle.
REQ-019 First tick SHALL be asserted P cycles after the first edge at which en is sampled high.
REQ-020 At each wrap: acc_next = acc + div_frac (mod 2^FRAC_W); carry-out sets next period P = div_int + 1, otherwise P = div_int.
REQ-021 rx_sync while rx_en high: RX cnt cleared, next tick_rx after floor(div_int/2) cycles (min 1), then full periods resume; acc unchanged.
REQ-022 rx_sync coinciding with an RX wrap SHALL take priority: tick_rx suppressed that cycle, half-period realign applies.
REQ-023 rx_sync while rx_en low SHALL be ignored.
REQ-024 Enable deassert mid-period SHALL discard the partial period; re-enable restarts per REQ-019.
REQ-025 Channels SHALL never interact; tx and rx ticks may coincide.

Reset
REQ-026 preset high at a pclk edge SHALL clear cnt, acc, shadows, tick_tx, tick_rx, div_err to 0.
REQ-027 preset has priority over all inputs; mid-operation reset drops any pending tick, and counting resumes per REQ-019 after release.

Configuration
REQ-028 Macro BAUD_FRAC_EN defined: fractional accumulator per REQ-020 present.
REQ-029 Macro BAUD_FRAC_EN undefined: acc logic absent, div_frac ignored, P = div_int always.

Verification
REQ-030 div_int=4, div_frac=0, tx_en high from cycle 0 -> tick_tx at cycles 4, 8, 12, each one cycle wide.
REQ-031 BAUD_FRAC_EN, FRAC_W=4, div_int=4, div_frac=8 -> tick intervals 4,4,5,4,5...; 9 cycles per 2 ticks; without macro -> constant 4.
REQ-032 div_int=16, rx_en high, rx_sync at cycle 21 -> tick_rx at cycle 29, then 45, 61.
REQ-033 div_int=1 -> div_err=1, ticks every 2 cycles; div_int set to 8 -> div_err=0, period 8 from next wrap.
REQ-034 div_int=10, preset pulsed at cycle 7 -> no tick at cycle 10; tick_tx 10 cycles after first enabled post-reset edge.
REQ-035 tx_en dropped at cycle 6 (div_int=8), re-raised at cycle 9 -> no tick before cycle 17; RX ticks unaffected throughout.
